// File: rtl/sad_accumulator.sv
// sad_accumulator: sums a fixed-length block of absolute-difference samples
// (SAD), tracks the block maximum, and hands the result to a downstream
// consumer over a valid/ready handshake.
//
//   state | meaning
//   ACCUM | accepting samples into acc / run_max, in_ready=1, out_valid=0
//   HOLD  | completed block held on sum / max_diff, in_ready=0, out_valid=1
module sad_accumulator #(
  parameter int DATA_W    = 5,
  parameter int BLOCK_LEN = 16,
  parameter int CNT_W     = 4,
  parameter int SUM_W     = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] diff,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SUM_W-1:0]  sum,
  output logic [DATA_W-1:0] max_diff,
  output logic [CNT_W-1:0]  sample_idx
);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t             state;
  logic [SUM_W-1:0]   acc;
  logic [DATA_W-1:0]  run_max;

  logic [SUM_W-1:0]   acc_next;
  logic [DATA_W-1:0]  max_next;
  logic               last_sample;

  // Next-value arithmetic; diff only reaches the registers when a sample is
  // actually accepted, so an undriven diff during idle cycles stays out of acc.
  assign acc_next    = acc + SUM_W'(diff);
  assign max_next    = (diff > run_max) ? diff : run_max;
  assign last_sample = (sample_idx == CNT_W'(BLOCK_LEN - 1));

  // Block FSM with registered handshake outputs and result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ACCUM;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      acc        <= '0;
      run_max    <= '0;
      sample_idx <= '0;
      sum        <= '0;
      max_diff   <= '0;
    end else begin
      case (state)
        ACCUM: begin
          if (in_valid) begin
            if (last_sample) begin
              sum        <= acc_next;
              max_diff   <= max_next;
              acc        <= '0;
              run_max    <= '0;
              sample_idx <= '0;
              state      <= HOLD;
              in_ready   <= 1'b0;
              out_valid  <= 1'b1;
            end else begin
              acc        <= acc_next;
              run_max    <= max_next;
              sample_idx <= sample_idx + CNT_W'(1);
            end
          end
        end
        HOLD: begin
          // The handoff edge consumes no input: one bubble per block.
          if (out_ready) begin
            state     <= ACCUM;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= ACCUM;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sad_accumulator.sv
// Testbench for sad_accumulator: table-driven block vectors, hand-written
// reset corner cases, and a randomized run against a queue-based model.
module tb_sad_accumulator;

  localparam int DATA_W    = 5;
  localparam int BLOCK_LEN = 16;
  localparam int CNT_W     = 4;
  localparam int SUM_W     = 9;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] diff;
  logic              out_valid;
  logic              out_ready;
  logic [SUM_W-1:0]  sum;
  logic [DATA_W-1:0] max_diff;
  logic [CNT_W-1:0]  sample_idx;

  sad_accumulator #(
    .DATA_W(DATA_W), .BLOCK_LEN(BLOCK_LEN), .CNT_W(CNT_W), .SUM_W(SUM_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .diff(diff), .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
    .max_diff(max_diff), .sample_idx(sample_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: samples of the open block, and the last published result.
  int m_block[$];
  bit m_hold;
  int m_sum;
  int m_max;
  int dut_results;
  bit prev_ov;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one clock: update the model from the inputs present at the edge,
  // then compare every DUT output just after the edge.
  task automatic cycle();
    int s;
    int mx;
    if (!rst_n) begin
      m_block.delete();
      m_hold = 0;
      m_sum  = 0;
      m_max  = 0;
    end else if (!m_hold) begin
      if (in_valid) begin
        m_block.push_back(int'(diff));
        if (m_block.size() == BLOCK_LEN) begin
          s = 0;
          mx = 0;
          foreach (m_block[k]) begin
            s += m_block[k];
            if (m_block[k] > mx) mx = m_block[k];
          end
          m_sum = s;
          m_max = mx;
          m_hold = 1;
          m_block.delete();
        end
      end
    end else if (out_ready) begin
      m_hold = 0;
    end
    @(posedge clk);
    #1;
    chk("out_valid", int'(out_valid), int'(m_hold));
    chk("in_ready", int'(in_ready), int'(!m_hold));
    chk("sample_idx", int'(sample_idx), m_block.size());
    chk("sum", int'(sum), m_sum);
    chk("max_diff", int'(max_diff), m_max);
    if (out_valid && !prev_ov) dut_results++;
    prev_ov = out_valid;
  endtask

  typedef struct {
    int kind;       // 0: constant val, 1: ramp 0..15, 2: |a-b| for a,b in 0..3
    int val;
    int gap_every;  // idle gap after every Nth sample (0 = none)
    int gap_len;
    int hold;       // cycles of out_ready=0 after the block completes
    int exp_sum;
    int exp_max;
  } vec_t;

  function automatic int sample_of(input vec_t v, input int i);
    int a;
    int b;
    case (v.kind)
      0: return v.val;
      1: return i;
      default: begin
        a = i / 4;
        b = i % 4;
        return (a > b) ? a - b : b - a;
      end
    endcase
  endfunction

  vec_t vecs[7];

  initial begin
    // Sum of |a-b| over the 16 ordered pairs a,b in 0..3 is 6*1+4*2+2*3 = 20.
    vecs[0] = '{0,  1, 0, 0,  0,  16,  1};
    vecs[1] = '{0, 31, 0, 0,  0, 496, 31};
    vecs[2] = '{1,  0, 4, 3,  0, 120, 15};
    vecs[3] = '{0,  1, 0, 0, 10,  16,  1};
    vecs[4] = '{2,  0, 0, 0,  0,  20,  3};
    vecs[5] = '{0,  0, 0, 0,  0,   0,  0};
    vecs[6] = '{1,  0, 1, 1,  3, 120, 15};

    rst_n = 1'b0; in_valid = 1'b0; diff = 'x; out_ready = 1'b0;
    prev_ov = 1'b0; dut_results = 0;
    cycle();
    cycle();
    rst_n = 1'b1;
    cycle();

    for (int v = 0; v < 7; v++) begin
      out_ready = (vecs[v].hold == 0);
      for (int i = 0; i < BLOCK_LEN; i++) begin
        in_valid = 1'b1;
        diff = DATA_W'(sample_of(vecs[v], i));
        cycle();
        if (vecs[v].gap_every != 0 && ((i + 1) % vecs[v].gap_every) == 0 &&
            i != BLOCK_LEN - 1) begin
          in_valid = 1'b0;
          diff = 'x;
          for (int g = 0; g < vecs[v].gap_len; g++) cycle();
        end
      end
      chk("tbl_out_valid", int'(out_valid), 1);
      chk("tbl_sum", int'(sum), vecs[v].exp_sum);
      chk("tbl_max", int'(max_diff), vecs[v].exp_max);
      in_valid = 1'b1;
      diff = 5'd7;
      for (int h = 0; h < vecs[v].hold; h++) cycle();
      if (vecs[v].hold != 0) begin
        chk("tbl_hold_sum", int'(sum), vecs[v].exp_sum);
        chk("tbl_hold_valid", int'(out_valid), 1);
      end
      out_ready = 1'b1;
      if (!out_valid) begin
        // The result would already have been consumed if out_ready was high.
        in_valid = 1'b0;
        diff = 'x;
      end
      cycle();
      in_valid = 1'b0;
      diff = 'x;
      chk("tbl_in_ready_after", int'(in_ready), 1);
      cycle();
    end

    // Partial block discarded by reset: 7 samples of 5, reset, 16 of 2.
    dut_results = 0;
    out_ready = 1'b1;
    in_valid = 1'b1;
    diff = 5'd5;
    for (int i = 0; i < 7; i++) cycle();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    diff = 5'd2;
    for (int i = 0; i < BLOCK_LEN; i++) cycle();
    in_valid = 1'b0;
    diff = 'x;
    chk("rst_mid_sum", int'(sum), 32);
    chk("rst_mid_max", int'(max_diff), 2);
    cycle();
    cycle();
    chk("rst_mid_results", dut_results, 1);

    // Pending result discarded by reset during HOLD.
    out_ready = 1'b0;
    in_valid = 1'b1;
    diff = 5'd9;
    for (int i = 0; i < BLOCK_LEN; i++) cycle();
    chk("rst_hold_pre", int'(out_valid), 1);
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    in_valid = 1'b0;
    diff = 'x;
    chk("rst_hold_valid", int'(out_valid), 0);
    chk("rst_hold_sum", int'(sum), 0);
    cycle();

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      in_valid = ($urandom_range(0, 3) != 0);
      diff = in_valid ? DATA_W'($urandom_range(0, 31)) : 'x;
      out_ready = ($urandom_range(0, 2) != 0);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
